// File: rtl/mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter_ctrl
//  Purpose  : Sequencing controller for a programmable mod-N up-counter.
//             A modulus and a period count are loaded through a valid/ready
//             handshake, then the count runs with pause and abort control,
//             flagging every wrap (tc_o) and the normal end of a run (done_o).
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_mod_i,
  input  logic [REP_W-1:0] cfg_reps_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  // Controller states
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  // Arithmetic constants sized to their operands
  localparam logic [WIDTH:0]   c_MOD_MIN = 2;
  localparam logic [WIDTH:0]   c_MOD_ONE = 1;
  localparam logic [WIDTH-1:0] c_Q_ONE   = 1;
  localparam logic [REP_W-1:0] c_PER_ONE = 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;
  // One bit wider than the count so that a modulus of 2^WIDTH is representable
  logic [WIDTH:0]   r_mod;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] r_per;

  logic [WIDTH:0]   w_mod_in;
  logic [WIDTH:0]   w_mod_clamped;
  logic             w_last;
  logic [REP_W-1:0] w_per_inc;

  // Zero-extend the requested modulus; 0 and 1 both clamp up to 2
  assign w_mod_in      = {1'b0, cfg_mod_i};
  assign w_mod_clamped = (w_mod_in < c_MOD_MIN) ? c_MOD_MIN : w_mod_in;

  // Count is at its final value for this period
  assign w_last    = ({1'b0, r_q} == (r_mod - c_MOD_ONE));
  assign w_per_inc = r_per + c_PER_ONE;

  // Status decode; tc_o only fires on an edge that actually advances the count
  assign cfg_ready_o = (r_state == c_S_IDLE);
  assign busy_o      = (r_state == c_S_RUN);
  assign done_o      = (r_state == c_S_DONE);
  assign tc_o        = (r_state == c_S_RUN) && !pause_i && w_last;
  assign q_o         = r_q;

  // Sequencer: handshake accept, abort > pause > count, single-cycle DONE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= c_S_IDLE;
      r_q     <= '0;
      r_mod   <= c_MOD_MIN;
      r_reps  <= '0;
      r_per   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_q <= '0;
          if (cfg_valid_i) begin
            r_mod   <= w_mod_clamped;
            r_reps  <= cfg_reps_i;
            r_per   <= '0;
            r_state <= c_S_RUN;
          end
        end
        c_S_RUN: begin
          if (abort_i) begin
            r_q     <= '0;
            r_per   <= '0;
            r_state <= c_S_IDLE;
          end else if (!pause_i) begin
            if (w_last) begin
              r_q <= '0;
              // A zero period count means free-running: never compared
              if (r_reps != '0) begin
                r_per <= w_per_inc;
                if (w_per_inc == r_reps) begin
                  r_state <= c_S_DONE;
                end
              end
            end else begin
              r_q <= r_q + c_Q_ONE;
            end
          end
        end
        c_S_DONE: begin
          r_q     <= '0;
          r_state <= c_S_IDLE;
        end
        default: begin
          r_q     <= '0;
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_counter_ctrl
//  Purpose  : Self-checking bench for mod_counter_ctrl: vector table, directed
//             multi-cycle sequences and randomized traffic against a
//             step-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int REP_W = 8;

  logic             clk_i;
  logic             rst_n_i;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [WIDTH-1:0] cfg_mod_i;
  logic [REP_W-1:0] cfg_reps_i;
  logic             pause_i;
  logic             abort_i;
  logic [WIDTH-1:0] q_o;
  logic             tc_o;
  logic             busy_o;
  logic             done_o;

  mod_counter_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_mod_i  (cfg_mod_i),
    .cfg_reps_i (cfg_reps_i),
    .pause_i    (pause_i),
    .abort_i    (abort_i),
    .q_o        (q_o),
    .tc_o       (tc_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is a number of elapsed count steps; the count is
  // steps mod M, and the run completes once steps reaches M*R (R != 0).
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;
  int m_phase = PH_IDLE;
  int m_steps = 0;
  int m_mod   = 2;
  int m_reps  = 0;

  typedef struct {
    logic v; int m; int r; logic p; logic a;
    int eq; logic etc; logic ebusy; logic edone; logic erdy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    chk("model_q",     int'(q_o),         (m_phase == PH_RUN) ? (m_steps % m_mod) : 0);
    chk("model_tc",    int'(tc_o),        (m_phase == PH_RUN && !pause_i &&
                                          (m_steps % m_mod) == m_mod - 1) ? 1 : 0);
    chk("model_busy",  int'(busy_o),      (m_phase == PH_RUN)  ? 1 : 0);
    chk("model_done",  int'(done_o),      (m_phase == PH_DONE) ? 1 : 0);
    chk("model_ready", int'(cfg_ready_o), (m_phase == PH_IDLE) ? 1 : 0);
  endtask

  task automatic model_step();
    case (m_phase)
      PH_IDLE: if (cfg_valid_i) begin
        m_mod   = (int'(cfg_mod_i) < 2) ? 2 : int'(cfg_mod_i);
        m_reps  = int'(cfg_reps_i);
        m_steps = 0;
        m_phase = PH_RUN;
      end
      PH_RUN: begin
        if (abort_i) begin
          m_phase = PH_IDLE;
          m_steps = 0;
        end else if (!pause_i) begin
          m_steps++;
          if (m_reps != 0 && m_steps == m_mod * m_reps) m_phase = PH_DONE;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  // Drive inputs just after a falling edge and compare against the model
  task automatic apply(input logic v, input int m, input int r, input logic p, input logic a);
    cfg_valid_i = v;
    cfg_mod_i   = WIDTH'(m);
    cfg_reps_i  = REP_W'(r);
    pause_i     = p;
    abort_i     = a;
    #1;
    model_check();
  endtask

  // Advance the model over the coming rising edge and return to the falling edge
  task automatic tick();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic add(input logic v, input int m, input int r, input logic p, input logic a,
                     input int eq, input logic etc, input logic eb, input logic ed, input logic er);
    vec_t e;
    e.v = v; e.m = m; e.r = r; e.p = p; e.a = a;
    e.eq = eq; e.etc = etc; e.ebusy = eb; e.edone = ed; e.erdy = er;
    tbl.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    rst_n_i = 1'b0; cfg_valid_i = 1'b0; cfg_mod_i = '0; cfg_reps_i = '0;
    pause_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_q", int'(q_o), 0);
    chk("reset_ready", int'(cfg_ready_o), 1);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_tc", int'(tc_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // ---------------- vector table ----------------
    // mod=3, reps=2: q 0,1,2,0,1,2; tc in cycles 3 and 6; done cycle 7; ready cycle 8
    add(1, 3, 2, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  2, 1, 1, 0, 0);
    add(1, 9, 5, 0, 0,  0, 0, 1, 0, 0);   // config during RUN is ignored
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    // modulus 0 clamps to 2, reps=1: q 0,1; tc at q=1; done cycle 3
    add(1, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].m, tbl[i].r, tbl[i].p, tbl[i].a);
      chk($sformatf("tbl%0d_q", i),     int'(q_o),         tbl[i].eq);
      chk($sformatf("tbl%0d_tc", i),    int'(tc_o),        int'(tbl[i].etc));
      chk($sformatf("tbl%0d_busy", i),  int'(busy_o),      int'(tbl[i].ebusy));
      chk($sformatf("tbl%0d_done", i),  int'(done_o),      int'(tbl[i].edone));
      chk($sformatf("tbl%0d_ready", i), int'(cfg_ready_o), int'(tbl[i].erdy));
      tick();
    end

    // ---------------- mod=15, reps=1: q 0..14, done in cycle 16 ----------------
    apply(1, 15, 1, 0, 0); tick();
    for (int k = 1; k <= 16; k++) begin
      apply(0, 0, 0, 0, 0);
      chk("m15_done", int'(done_o), (k == 16) ? 1 : 0);
      if (k <= 15) chk("m15_q", int'(q_o), k - 1);
      tick();
    end
    apply(0, 0, 0, 0, 0); tick();

    // ---------------- pause: mod=4, reps=1, pause 3 cycles at q=1 ----------------
    apply(1, 4, 1, 0, 0); tick();
    for (int k = 1; k <= 9; k++) begin
      apply(0, 0, 0, (k >= 2 && k <= 4) ? 1'b1 : 1'b0, 0);
      if (k >= 2 && k <= 5) chk("pause_q_hold", int'(q_o), 1);
      chk("pause_tc", int'(tc_o), (k == 7) ? 1 : 0);
      chk("pause_done", int'(done_o), (k == 8) ? 1 : 0);
      tick();
    end

    // ---------------- abort with tc: mod=5, reps=0 ----------------
    apply(1, 5, 0, 0, 0); tick();
    for (int k = 1; k <= 4; k++) begin apply(0, 0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0, 1);
    chk("abort_q4", int'(q_o), 4);
    chk("abort_tc", int'(tc_o), 1);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("abort_ready", int'(cfg_ready_o), 1);
    chk("abort_q0", int'(q_o), 0);
    chk("abort_done", int'(done_o), 0);
    tick();

    // ---------------- back-to-back: valid held high through DONE ----------------
    apply(1, 2, 1, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      apply(1, 2, 1, 0, 0);
      if (k == 3) chk("b2b_ready_done", int'(cfg_ready_o), 0);
      if (k == 4) chk("b2b_ready_idle", int'(cfg_ready_o), 1);
      if (k == 5) begin
        chk("b2b_busy", int'(busy_o), 1);
        chk("b2b_q", int'(q_o), 0);
      end
      tick();
    end
    apply(0, 0, 0, 1, 1); tick();   // abort the second run

    // ---------------- largest period count: mod=2, reps=255 ----------------
    apply(1, 2, 255, 0, 0); tick();
    for (int k = 1; k <= 511; k++) begin
      apply(0, 0, 0, 0, 0);
      chk("r255_done", int'(done_o), (k == 511) ? 1 : 0);
      tick();
    end
    apply(0, 0, 0, 0, 0); tick();

    // ---------------- asynchronous reset mid-run at q=2 ----------------
    apply(1, 5, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0);
    chk("arst_pre_q", int'(q_o), 2);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_q", int'(q_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_ready", int'(cfg_ready_o), 1);
    chk("arst_tc", int'(tc_o), 0);
    chk("arst_done", int'(done_o), 0);
    m_phase = PH_IDLE; m_steps = 0; m_mod = 2; m_reps = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    apply(0, 0, 0, 0, 0);
    chk("arst_release_ready", int'(cfg_ready_o), 1);
    tick();

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
